// File: rtl/clock_ui_pkg.sv
// Shared types and helpers for the wall-clock adjustment UI.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    FIELD_RUN     = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_SECONDS = 2'd3
  } field_t;

  localparam logic [5:0] MASK_HOURS   = 6'b110000;
  localparam logic [5:0] MASK_MINUTES = 6'b001100;
  localparam logic [5:0] MASK_SECONDS = 6'b000011;

  function automatic int unsigned ms_to_cycles(input int unsigned rate_hz, input int unsigned ms);
    return rate_hz / 1000 * ms;
  endfunction

  // Cyclic field order used by the next switch.
  function automatic field_t next_field(input field_t f);
    next_field = FIELD_RUN;
    case (f)
      FIELD_RUN:     next_field = FIELD_HOURS;
      FIELD_HOURS:   next_field = FIELD_MINUTES;
      FIELD_MINUTES: next_field = FIELD_SECONDS;
      FIELD_SECONDS: next_field = FIELD_RUN;
    endcase
  endfunction

  function automatic logic [5:0] field_mask(input field_t f);
    field_mask = 6'b000000;
    case (f)
      FIELD_RUN:     field_mask = 6'b000000;
      FIELD_HOURS:   field_mask = MASK_HOURS;
      FIELD_MINUTES: field_mask = MASK_MINUTES;
      FIELD_SECONDS: field_mask = MASK_SECONDS;
    endcase
  endfunction

endpackage

// File: rtl/clock_adjust_controller_button_conditioner.sv
// Switch conditioner: 2-FF synchronizer, counting debouncer and rising-edge press pulse.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Level flips once the synchronized input has disagreed for DEBOUNCE_CYCLES samples;
  // the press pulse is issued on the same edge as the rising flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_adjust_controller.sv
// Field-select FSM, increment strobes and blink mask for clock adjustment.
// Optional auto-repeat of held increment presses: define AUTO_REPEAT_EN.
module clock_adjust_controller
  import clock_ui_pkg::*;
#(
  parameter int unsigned CLK_RATE_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS      = 10,
  parameter int unsigned BLINK_HZ         = 2,
  parameter int unsigned REPEAT_DELAY_MS  = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_increment,
  output logic [1:0] field,
  output logic       adjusting,
  output logic       inc_hours,
  output logic       inc_minutes,
  output logic       inc_seconds,
  output logic [5:0] digit_blank_mask
);

  localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_RATE_HZ, DEBOUNCE_MS);
  localparam int unsigned HALF_CYCLES     = CLK_RATE_HZ / (2 * BLINK_HZ);
  localparam int unsigned BW              = $clog2(HALF_CYCLES) + 1;

  logic          next_level;
  logic          next_press;
  logic          inc_level;
  logic          inc_press;
  logic          inc_req_c;
  field_t        state;
  logic          phase;
  logic [BW-1:0] blink_cnt;
  logic          unused_levels;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .level (next_level),
    .press (next_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_increment (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_increment),
    .level (inc_level),
    .press (inc_press)
  );

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REPEAT_DELAY  = ms_to_cycles(CLK_RATE_HZ, REPEAT_DELAY_MS);
  localparam int unsigned REPEAT_PERIOD = ms_to_cycles(CLK_RATE_HZ, REPEAT_PERIOD_MS);
  localparam int unsigned RW            = $clog2(REPEAT_DELAY) + 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_fire_c;

  assign rep_fire_c = inc_level && (state != FIELD_RUN) && (rep_cnt == RW'(REPEAT_DELAY - 1));
  assign inc_req_c  = inc_press | rep_fire_c;
  assign unused_levels = next_level;

  // Hold timer: first repeat REPEAT_DELAY after the debounced rise, then every REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (!inc_level || state == FIELD_RUN || next_press) begin
      rep_cnt <= '0;
    end else if (rep_fire_c) begin
      rep_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  localparam int unsigned unused_repeat_ms = REPEAT_DELAY_MS + REPEAT_PERIOD_MS;

  assign inc_req_c     = inc_press;
  assign unused_levels = next_level ^ inc_level;
`endif

  assign field = state;

  // Next has priority over increment; any field change or strobe restarts the blink visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FIELD_RUN;
      adjusting        <= 1'b0;
      inc_hours        <= 1'b0;
      inc_minutes      <= 1'b0;
      inc_seconds      <= 1'b0;
      digit_blank_mask <= 6'b000000;
      phase            <= 1'b0;
      blink_cnt        <= '0;
    end else begin
      inc_hours   <= 1'b0;
      inc_minutes <= 1'b0;
      inc_seconds <= 1'b0;
      if (next_press) begin
        state            <= next_field(state);
        adjusting        <= (next_field(state) != FIELD_RUN);
        blink_cnt        <= '0;
        phase            <= 1'b0;
        digit_blank_mask <= 6'b000000;
      end else if (inc_req_c && state != FIELD_RUN) begin
        case (state)
          FIELD_RUN:     ;
          FIELD_HOURS:   inc_hours   <= 1'b1;
          FIELD_MINUTES: inc_minutes <= 1'b1;
          FIELD_SECONDS: inc_seconds <= 1'b1;
        endcase
        blink_cnt        <= '0;
        phase            <= 1'b0;
        digit_blank_mask <= 6'b000000;
      end else if (state == FIELD_RUN) begin
        blink_cnt        <= '0;
        phase            <= 1'b0;
        digit_blank_mask <= 6'b000000;
      end else if (blink_cnt == BW'(HALF_CYCLES - 1)) begin
        blink_cnt        <= '0;
        phase            <= ~phase;
        digit_blank_mask <= phase ? 6'b000000 : field_mask(state);
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_adjust_controller.sv
// Directed bench for clock_adjust_controller (1 kHz clock, 2-cycle debounce, 5-cycle blink half-period).
module tb_clock_adjust_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_increment;
  logic [1:0] field;
  logic       adjusting;
  logic       inc_hours;
  logic       inc_minutes;
  logic       inc_seconds;
  logic [5:0] digit_blank_mask;

  int errors = 0;
  int checks = 0;

  clock_adjust_controller #(
    .CLK_RATE_HZ      (1000),
    .DEBOUNCE_MS      (2),
    .BLINK_HZ         (100),
    .REPEAT_DELAY_MS  (6),
    .REPEAT_PERIOD_MS (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_next         (btn_next),
    .btn_increment    (btn_increment),
    .field            (field),
    .adjusting        (adjusting),
    .inc_hours        (inc_hours),
    .inc_minutes      (inc_minutes),
    .inc_seconds      (inc_seconds),
    .digit_blank_mask (digit_blank_mask)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_mask(input int f);
    case (f)
      1:       return 6'b110000;
      2:       return 6'b001100;
      3:       return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic press_next();
    btn_next = 1'b1;
    step(10);
    btn_next = 1'b0;
    step(10);
  endtask

  initial begin
    logic [2:0] incs_seen;
    logic       exp_pulse;

    rst = 1'b1;
    btn_next = 1'b0;
    btn_increment = 1'b0;
    step(3);
    check("reset_field", 8'(field), 8'd0);
    check("reset_adjusting", 8'(adjusting), 8'd0);
    check("reset_mask", 8'(digit_blank_mask), 8'd0);
    check("reset_incs", 8'({inc_hours, inc_minutes, inc_seconds}), 8'd0);
    rst = 1'b0;
    step(2);

    // Four clean next presses: change lands at press+5, blink goes invisible 5 cycles later.
    for (int p = 0; p < 4; p++) begin
      btn_next = 1'b1;
      step(4);
      check("next_before", 8'(field), 8'(p));
      step(1);
      check("next_after", 8'(field), 8'((p + 1) % 4));
      check("next_adjusting", 8'(adjusting), 8'(p != 3));
      check("next_mask_visible", 8'(digit_blank_mask), 8'd0);
      step(5);
      btn_next = 1'b0;
      check("next_mask_invisible", 8'(digit_blank_mask), 8'(exp_mask((p + 1) % 4)));
      step(5);
      check("next_mask_revisible", 8'(digit_blank_mask), 8'd0);
      step(5);
    end

    // Glitch and 1-0-1 bounce on increment in HOURS must not strobe.
    press_next();
    check("hours_entered", 8'(field), 8'd1);
    incs_seen = 3'b000;
    btn_increment = 1'b1;
    step(1);
    btn_increment = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      incs_seen |= {inc_hours, inc_minutes, inc_seconds};
    end
    check("glitch_no_inc", 8'(incs_seen), 8'd0);
    btn_increment = 1'b1;
    step(1);
    btn_increment = 1'b0;
    step(1);
    btn_increment = 1'b1;
    step(1);
    btn_increment = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      incs_seen |= {inc_hours, inc_minutes, inc_seconds};
    end
    check("bounce_no_inc", 8'(incs_seen), 8'd0);
    check("bounce_field", 8'(field), 8'd1);

    // Increment held 20 cycles in MINUTES.
    press_next();
    check("minutes_entered", 8'(field), 8'd2);
    btn_increment = 1'b1;
    for (int i = 1; i < 20; i++) begin
      step(1);
`ifdef AUTO_REPEAT_EN
      exp_pulse = (i == 5) || (i == 10) || (i == 12) || (i == 14) || (i == 16) || (i == 18);
`else
      exp_pulse = (i == 5);
`endif
      check("hold_incs", 8'({inc_hours, inc_minutes, inc_seconds}), 8'({1'b0, exp_pulse, 1'b0}));
      if (exp_pulse)
        check("hold_mask_visible", 8'(digit_blank_mask), 8'd0);
`ifndef AUTO_REPEAT_EN
      if (i == 10)
        check("hold_mask_invisible", 8'(digit_blank_mask), 8'b001100);
`endif
    end
    step(1);
    btn_increment = 1'b0;
    step(15);
    check("hold_field", 8'(field), 8'd2);

    // Simultaneous next and increment in SECONDS: next wins.
    press_next();
    check("seconds_entered", 8'(field), 8'd3);
    btn_next = 1'b1;
    btn_increment = 1'b1;
    incs_seen = 3'b000;
    step(4);
    check("simul_before", 8'(field), 8'd3);
    for (int i = 0; i < 6; i++) begin
      step(1);
      incs_seen |= {inc_hours, inc_minutes, inc_seconds};
    end
    check("simul_field", 8'(field), 8'd0);
    check("simul_no_inc", 8'(incs_seen), 8'd0);
    btn_next = 1'b0;
    btn_increment = 1'b0;
    step(10);

    // Reset in HOURS while blanked, with an increment press in flight.
    press_next();
    check("rst_pre_field", 8'(field), 8'd1);
    check("rst_pre_mask", 8'(digit_blank_mask), 8'b110000);
    btn_increment = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_mid_field", 8'(field), 8'd0);
    check("rst_mid_mask", 8'(digit_blank_mask), 8'd0);
    check("rst_mid_adjusting", 8'(adjusting), 8'd0);
    incs_seen = 3'b000;
    for (int i = 0; i < 15; i++) begin
      step(1);
      incs_seen |= {inc_hours, inc_minutes, inc_seconds};
    end
    check("rst_no_inc", 8'(incs_seen), 8'd0);
    check("rst_post_field", 8'(field), 8'd0);
    btn_increment = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_adjust_controller.md
# clock_adjust_controller

Sequences the user-facing time adjustment of the 7-segment wall clock. Conditions the two raw board switches (next, increment), runs a field-select state machine (run → hours → minutes → seconds → run), and emits single-cycle increment strobes to the timekeeping counters. It also provides a digit blink mask so the display driver can flash the field being edited. It sits between the board switch pins and the clock/display datapath.

## Interface
- CLK_RATE_HZ, 100_000_000: input clock frequency.
- DEBOUNCE_MS, 10: input stable time required before a level is accepted.
- BLINK_HZ, 2: blink frequency of the selected field.
- REPEAT_DELAY_MS, 500: hold time before auto-repeat starts (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD_MS, 100: auto-repeat interval (used only with AUTO_REPEAT_EN).

- clk in 1: system clock.
- rst in 1: reset. Synchronous, active-high.
- btn_next in 1: raw next switch; asynchronous, may bounce.
- btn_increment in 1: raw increment switch; asynchronous, may bounce.
- field out 2: current state (0 run, 1 hours, 2 minutes, 3 seconds).
- adjusting out 1: high whenever field ≠ 0. The clock freezes its seconds tick while this is high.
- inc_hours, inc_minutes, inc_seconds out 1 each: one-cycle increment strobes.
- digit_blank_mask out 6: bit per digit; bits 5:4 hours, 3:2 minutes, 1:0 seconds. 1 = blank.

## Operation
- Each switch path: 2-FF synchronizer, then debouncer.
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES = CLK_RATE_HZ/1000*DEBOUNCE_MS consecutive cycles.
  - Any sample that agrees with the current debounced level resets the count.
  - A rising edge of the debounced level produces one press pulse.
- FSM states: RUN, HOURS, MINUTES, SECONDS.
  - A next press advances cyclically: RUN→HOURS→MINUTES→SECONDS→RUN.
  - An increment press in HOURS, MINUTES or SECONDS pulses the matching inc_* output.
  - An increment press in RUN is ignored.
- Simultaneous next and increment presses in the same cycle: next wins and the increment is dropped.
- Blink:
  - A half-period counter of CLK_RATE_HZ/(2*BLINK_HZ) cycles toggles the phase.
  - The phase is forced to "visible" and the counter cleared on every field change and every inc_* pulse.
- digit_blank_mask: the selected field's two bits are 1 during the invisible phase. It is 0 in RUN and 0 in all other bits.
- Counter widths are $clog2 of the largest cycle count plus 1. No counter wraps; each saturates or reloads at its terminal value.

## Timing
- Reset (rst high at a clk edge) values: field=0, adjusting=0, all inc_*=0, digit_blank_mask=0, debounced levels=0, blink phase visible, all counters 0.
- Reset mid-operation: state returns to RUN on the next edge, and any pending press is discarded.
- All outputs are registered.
- Latency: given a clean raw edge at cycle 0, the press-driven output changes at cycle DEBOUNCE_CYCLES+3. This applies to both the field update and the inc_* pulse.
- inc_* pulses are exactly one cycle wide, and at most one inc_* is high per cycle.
- A press held indefinitely produces one pulse, except as modified by AUTO_REPEAT_EN.
- Bounces shorter than DEBOUNCE_CYCLES produce no pulse and no state change.

## Configuration
- AUTO_REPEAT_EN:
  - Defined: while the increment debounced level stays high in an adjust state, an extra inc_* pulse is issued REPEAT_DELAY_MS after the debounced rise, then every REPEAT_PERIOD_MS. Releasing the switch or a field change stops repeating and clears the repeat timer.
  - Undefined: exactly one pulse per press, and no repeat counter is synthesized.

## Structure
- Package clock_ui_pkg holds:
  - field_t enum (FIELD_RUN=0, FIELD_HOURS=1, FIELD_MINUTES=2, FIELD_SECONDS=3).
  - Blank-mask constants per field (6'b110000, 6'b001100, 6'b000011).
  - Function ms_to_cycles(rate_hz, ms).
- Sub-module button_conditioner: synchronizer, debouncer and rising-edge pulse. It has parameter DEBOUNCE_CYCLES and outputs level and press. It is instantiated twice.

## Test plan
All cases use CLK_RATE_HZ=1000, DEBOUNCE_MS=2 (2 cycles), BLINK_HZ=100 (5-cycle half-period), REPEAT_DELAY_MS=6, REPEAT_PERIOD_MS=2.
- Reset: hold rst 3 cycles → field=0, adjusting=0, mask=0, all inc_*=0.
- Four clean next presses (10 cycles high, 10 low): field 1,2,3,0 with each change at press+5 cycles. In the invisible phase the mask is 110000, then 001100, then 000011, and 0 in RUN.
- A 1-cycle glitch on btn_increment in HOURS, and a 1-0-1 bounce pattern: no inc_hours, field unchanged.
- Clean increment held 20 cycles in MINUTES:
  - Without macro: single inc_minutes at cycle 5.
  - With AUTO_REPEAT_EN: pulses at cycles 5, 10, 12, 14, 16, 18.
  - Blink phase is visible after each pulse.
- Next and increment raw edges in the same cycle in SECONDS: field→0 at +5 cycles, no inc_seconds.
- rst pulsed while in HOURS during the invisible phase: next cycle field=0, mask=0, and a press in progress produces no pulse afterwards.
